// File: rtl/fetch_stage_pkg.sv
// Package rv32i_types: shared RV32I word/opcode types plus fetch-stage
// state encoding, the canonical NOP and the IF/ID payload struct.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } fetch_state_t;

    // addi x0, x0, 0
    localparam rv32i_word RV32I_NOP = 32'h0000_0013;

    // One IF/ID payload: used for both the park buffer and the IF/ID register.
    typedef struct packed {
        rv32i_word pc_plus4;
        rv32i_word instr;
        logic      is_branch;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_predecode.sv
// fetch_predecode: combinational branch predecoder for the fetch stage.
// Extracts the B-type immediate and predicts taken for backward branches.
// Only instantiated when FETCH_BTFN_PREDICT_EN is defined.
module fetch_predecode
    import rv32i_types::*;
(
    input  rv32i_word instr,
    output rv32i_word b_imm,
    output logic      pred_taken
);

    // rs1/rs2/funct3 play no part in the prediction.
    logic unused_fields;
    assign unused_fields = ^instr[24:12];

    assign b_imm      = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign pred_taken = (rv32i_opcode'(instr[6:0]) == op_br) && b_imm[31];

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage, producer of the IF/ID interface.
// Holds the PC, runs a read/resp handshake with instruction memory, parks a
// fetched instruction while decode stalls, and redirects on branch_recovery.
// A redirect that arrives while a read is outstanding marks it stale (squash)
// so its response is dropped.
// Optional feature macro: FETCH_BTFN_PREDICT_EN (backward-taken/forward-not-taken
// static prediction); without it next_pc is always pc+4.
module fetch_stage
    import rv32i_types::*;
#(
    parameter rv32i_word RESET_PC  = 32'h0000_0060,
    parameter rv32i_word NOP_INSTR = RV32I_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_recovery,
    input  logic [31:0] recovery_pc,
    output logic        mem_read,
    output logic [31:0] mem_address,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,
    output logic [31:0] IF_ID_pc_plus4,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_is_branch,
    output logic        IF_ID_valid
);

    fetch_state_t state;
    fetch_state_t next_state;

    rv32i_word pc;
    rv32i_word redirect_pc;
    rv32i_word pc_plus4;
    rv32i_word next_pc;
    rv32i_word recovery_target;
    rv32i_word park_next_pc;
    logic      squash;
    logic      pred_taken;
    logic      park_load;
    logic      if_id_valid;
    if_id_t    fetched;
    if_id_t    park;
    if_id_t    if_id;

    // Redirect targets are always word aligned.
    logic unused_recovery_lsbs;
    assign unused_recovery_lsbs = ^recovery_pc[1:0];
    assign recovery_target      = {recovery_pc[31:2], 2'b00};

    assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_BTFN_PREDICT_EN
    rv32i_word b_imm;

    fetch_predecode u_predecode (
        .instr      (mem_rdata),
        .b_imm      (b_imm),
        .pred_taken (pred_taken)
    );

    assign next_pc = pred_taken ? (pc + b_imm) : pc_plus4;
`else
    assign pred_taken = 1'b0;
    assign next_pc    = pc_plus4;
`endif

    assign fetched = '{pc_plus4: pc_plus4, instr: mem_rdata, is_branch: pred_taken};

    // A response that is neither stale nor redirected, arriving under stall, is parked.
    assign park_load = (state == FETCH) && mem_resp && !branch_recovery && !squash && stall;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    // NOTE: next_state gets a default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = FETCH;
            FETCH:   if (park_load) next_state = HOLD;
            HOLD:    if (branch_recovery || !stall) next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    // Memory request outputs: a read is outstanding exactly while in FETCH.
    always_comb begin
        mem_read    = (state == FETCH);
        mem_address = pc;
    end

    // Park buffer: captures the instruction that decode could not accept.
    // NOTE: no reset here; the buffer is only read in HOLD, which is entered only after a load.
    always_ff @(posedge clk) begin
        if (park_load) begin
            park         <= fetched;
            park_next_pc <= next_pc;
        end
    end

    // PC, redirect tracking and IF/ID register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            redirect_pc <= '0;
            squash      <= 1'b0;
            if_id_valid <= 1'b0;
            if_id       <= '{pc_plus4: '0, instr: NOP_INSTR, is_branch: 1'b0};
        end else begin
            case (state)
                IDLE: begin
                    if (branch_recovery) pc <= recovery_target;
                end
                FETCH: begin
                    if (mem_resp) begin
                        if (branch_recovery || squash) begin
                            // Response belongs to a path that has been abandoned.
                            pc          <= branch_recovery ? recovery_target : redirect_pc;
                            squash      <= 1'b0;
                            if_id_valid <= 1'b0;
                        end else if (!stall) begin
                            if_id       <= fetched;
                            if_id_valid <= 1'b1;
                            pc          <= next_pc;
                        end
                    end else if (branch_recovery) begin
                        // Keep the outstanding address stable; redirect once it returns.
                        redirect_pc <= recovery_target;
                        squash      <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (branch_recovery) begin
                        pc          <= recovery_target;
                        if_id_valid <= 1'b0;
                    end else if (!stall) begin
                        if_id       <= park;
                        if_id_valid <= 1'b1;
                        pc          <= park_next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign IF_ID_pc_plus4  = if_id.pc_plus4;
    assign IF_ID_instr     = if_id_valid ? if_id.instr : NOP_INSTR;
    assign IF_ID_is_branch = if_id.is_branch;
    assign IF_ID_valid     = if_id_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
// Stimulus pushes the expected IF/ID payloads; a monitor pops one each time
// decode would accept an instruction (valid && !stall) and compares it.
// A behavioural memory answers each request after a programmable latency.
module tb_fetch_stage;

    typedef struct {
        logic [31:0] pc_plus4;
        logic [31:0] instr;
        logic        is_branch;
    } exp_t;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3; // beq x0, x0, -16

`ifdef FETCH_BTFN_PREDICT_EN
    localparam logic PRED = 1'b1;
`else
    localparam logic PRED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_recovery;
    logic [31:0] recovery_pc;
    logic        mem_read;
    logic [31:0] mem_address;
    logic [31:0] mem_rdata = 32'hDEAD_BEEF;
    logic        mem_resp = 1'b0;
    logic [31:0] IF_ID_pc_plus4;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_is_branch;
    logic        IF_ID_valid;

    int   n_checks = 0;
    int   n_fail = 0;
    int   lat = 1;
    int   cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_recovery (branch_recovery),
        .recovery_pc     (recovery_pc),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .IF_ID_pc_plus4  (IF_ID_pc_plus4),
        .IF_ID_instr     (IF_ID_instr),
        .IF_ID_is_branch (IF_ID_is_branch),
        .IF_ID_valid     (IF_ID_valid)
    );

    // Instruction image: a non-branch addi tagged with its address, and a beq at 0x80.
    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0000_0080) return BEQ_M16;
        return {a[11:0], 5'd0, 3'b000, 5'd1, 7'b0010011};
    endfunction

    function automatic exp_t mk(input logic [31:0] p4, input logic [31:0] ins, input logic br);
        exp_t e;
        e.pc_plus4  = p4;
        e.instr     = ins;
        e.is_branch = br;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Memory model: answers after 'lat' cycles of an asserted request.
    always @(posedge clk) begin
        #1;
        if (rst || !mem_read) begin
            cnt       = 0;
            mem_resp  = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
        end else begin
            cnt++;
            if (cnt >= lat) begin
                mem_resp  = 1'b1;
                mem_rdata = imem(mem_address);
                cnt       = 0;
            end else begin
                mem_resp  = 1'b0;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: sampled just before the edge at which decode accepts IF/ID.
    always @(negedge clk) begin
        #3;
        if (!rst) begin
            if (!IF_ID_valid) check("nop_when_invalid", IF_ID_instr, NOP);
            if (IF_ID_valid && !stall) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc_plus4 0x%08h instr 0x%08h, required no instruction",
                             IF_ID_pc_plus4, IF_ID_instr);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_pc_plus4", IF_ID_pc_plus4, e.pc_plus4);
                    check("sb_instr", IF_ID_instr, e.instr);
                    check("sb_is_branch", {31'd0, IF_ID_is_branch}, {31'd0, e.is_branch});
                end
            end
        end
    end

    task automatic do_reset(input int l);
        sb.delete();
        rst             = 1'b1;
        stall           = 1'b0;
        branch_recovery = 1'b0;
        recovery_pc     = '0;
        lat             = l;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("rst_instr", IF_ID_instr, NOP);
        check("rst_pc_plus4", IF_ID_pc_plus4, 32'd0);
        check("rst_is_branch", {31'd0, IF_ID_is_branch}, 32'd0);
        check("rst_mem_read", {31'd0, mem_read}, 32'd0);
        check("rst_address", mem_address, 32'h0000_0060);
        rst = 1'b0;
    endtask

    // Waits (bounded) for the negedge at which a response is visible, then checks its address.
    task automatic wait_resp(input logic [31:0] addr, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_resp) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no mem_resp in 40 cycles, required a response", name);
        end else begin
            check(name, mem_address, addr);
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        check({name, "_drained"}, sb.size(), 32'd0);
        check({name, "_idle_valid"}, {31'd0, IF_ID_valid}, 32'd0);
    endtask

    // Reset, then redirect the first (stalled) request to 'target'.
    task automatic start_at(input logic [31:0] target);
        do_reset(50);
        @(negedge clk);
        check("start_read", {31'd0, mem_read}, 32'd1);
        branch_recovery = 1'b1;
        recovery_pc     = target;
        @(negedge clk);
        branch_recovery = 1'b0;
        lat             = 1;
        wait_resp(32'h0000_0060, "start_squashed_addr");
        check("start_squashed_valid", {31'd0, IF_ID_valid}, 32'd0);
    endtask

    initial begin
        // 1: straight-line fetch, 1-cycle memory
        do_reset(1);
        sb.push_back(mk(32'h64, imem(32'h60), 1'b0));
        sb.push_back(mk(32'h68, imem(32'h64), 1'b0));
        sb.push_back(mk(32'h6C, imem(32'h68), 1'b0));
        wait_resp(32'h60, "t1_addr0");
        wait_resp(32'h64, "t1_addr1");
        wait_resp(32'h68, "t1_addr2");
        lat = 50;
        drain("t1");

        // 2: stall for 3 cycles at the response of 0x64
        do_reset(1);
        sb.push_back(mk(32'h64, imem(32'h60), 1'b0));
        sb.push_back(mk(32'h68, imem(32'h64), 1'b0));
        sb.push_back(mk(32'h6C, imem(32'h68), 1'b0));
        wait_resp(32'h60, "t2_addr0");
        wait_resp(32'h64, "t2_addr1");
        stall = 1'b1;
        @(negedge clk);
        check("t2_hold_read", {31'd0, mem_read}, 32'd0);
        check("t2_hold_instr", IF_ID_instr, imem(32'h60));
        check("t2_hold_pc_plus4", IF_ID_pc_plus4, 32'h64);
        repeat (2) @(negedge clk);
        check("t2_hold_read_late", {31'd0, mem_read}, 32'd0);
        stall = 1'b0;
        wait_resp(32'h68, "t2_addr2");
        lat = 50;
        check("t2_unparked_instr", IF_ID_instr, imem(32'h64));
        drain("t2");

        // 3: redirect to 0x200 while a 4-cycle fetch of 0x70 is outstanding
        do_reset(1);
        sb.push_back(mk(32'h64, imem(32'h60), 1'b0));
        sb.push_back(mk(32'h68, imem(32'h64), 1'b0));
        sb.push_back(mk(32'h6C, imem(32'h68), 1'b0));
        sb.push_back(mk(32'h70, imem(32'h6C), 1'b0));
        sb.push_back(mk(32'h204, imem(32'h200), 1'b0));
        wait_resp(32'h60, "t3_addr0");
        wait_resp(32'h64, "t3_addr1");
        wait_resp(32'h68, "t3_addr2");
        wait_resp(32'h6C, "t3_addr3");
        lat = 4;
        @(negedge clk);
        check("t3_pending_addr", mem_address, 32'h70);
        branch_recovery = 1'b1;
        recovery_pc     = 32'h0000_0203;
        @(negedge clk);
        branch_recovery = 1'b0;
        recovery_pc     = '0;
        check("t3_flush_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("t3_addr_stable", mem_address, 32'h70);
        wait_resp(32'h70, "t3_stale_addr");
        lat = 1;
        wait_resp(32'h200, "t3_redirect_addr");
        check("t3_stale_dropped", {31'd0, IF_ID_valid}, 32'd0);
        lat = 50;
        drain("t3");

        // 4: redirect with stall held while an instruction is parked
        do_reset(1);
        sb.push_back(mk(32'h204, imem(32'h200), 1'b0));
        wait_resp(32'h60, "t4_addr0");
        wait_resp(32'h64, "t4_addr1");
        stall = 1'b1;
        @(negedge clk);
        check("t4_hold_read", {31'd0, mem_read}, 32'd0);
        branch_recovery = 1'b1;
        recovery_pc     = 32'h200;
        @(negedge clk);
        branch_recovery = 1'b0;
        stall           = 1'b0;
        check("t4_flush_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("t4_resp", {31'd0, mem_resp}, 32'd1);
        check("t4_redirect_addr", mem_address, 32'h200);
        lat = 50;
        drain("t4");

        // 5: PC wrap at the top of the address space
        start_at(32'hFFFF_FFFC);
        sb.push_back(mk(32'h0, imem(32'hFFFF_FFFC), 1'b0));
        sb.push_back(mk(32'h4, imem(32'h0), 1'b0));
        wait_resp(32'hFFFF_FFFC, "t5_addr_top");
        wait_resp(32'h0, "t5_addr_wrap");
        lat = 50;
        check("t5_pc_plus4_wrap", IF_ID_pc_plus4, 32'h0);
        drain("t5");

        // 6: backward beq at 0x80 (offset -16)
        begin
            logic [31:0] nxt;
            nxt = PRED ? 32'h70 : 32'h84;
            start_at(32'h80);
            sb.push_back(mk(32'h84, BEQ_M16, PRED));
            sb.push_back(mk(nxt + 32'd4, imem(nxt), 1'b0));
            wait_resp(32'h80, "t6_addr_branch");
            wait_resp(nxt, "t6_addr_next");
            lat = 50;
            check("t6_is_branch", {31'd0, IF_ID_is_branch}, {31'd0, PRED});
            drain("t6");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test by 100000 time units, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
